star_actuator_model: RTL and testbench
======================================

STAR_ACTUATOR_MODEL -- requirements
Module: star_actuator_model

Interface
REQ-001 Parameter GRILL_TRAVEL, default 100: grill travel length in steps, closed (0) to open (GRILL_TRAVEL), range 2..1023.
REQ-002 Parameter STAR_TRAVEL, default 60: star travel length in steps, extended/up (0) to hidden (STAR_TRAVEL), range 2..1023.
REQ-003 Parameter STEP_DIV, default 4: clocks per motion step, range 1..255.
REQ-004 Parameters INIT_GRILL, default 0, and INIT_STAR, default 0: position counter values loaded at reset.
REQ-005 i_clk  input  1  system clock, all logic on rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_cmd  input  4  motor commands: [3] grill open, [2] grill close, [1] star retract, [0] star extend.
REQ-008 o_grill_pos  output  2  grill position code: 00 closed, 01 open, 10 between, 11 never driven.
REQ-009 o_star_pos  output  2  star position code: 00 extended, 01 hidden, 10 between, 11 never driven.
REQ-010 o_fault  output  1  sticky illegal-command flag.

Function
REQ-011 Prescaler counts 0..STEP_DIV-1 continuously and asserts an internal step tick when it reaches STEP_DIV-1; motion evaluates only on tick cycles.
REQ-012 On a tick, grill counter +1 if i_cmd[3] alone among grill bits, -1 if i_cmd[2] alone; star counter +1 if i_cmd[1] alone, -1 if i_cmd[0] alone.
REQ-013 Counters saturate at 0 and at TRAVEL; a command pushing past an endpoint holds the counter and is not a fault.
REQ-014 Position codes are combinational decodes of the registered counters: 0 -> 00, TRAVEL -> 01, otherwise 10; latency from command to code change is one tick.
REQ-015 Interlock A: a grill command while star counter != 0 holds the grill counter and raises fault.
REQ-016 Interlock B: a star command while grill counter != GRILL_TRAVEL holds the star counter and raises fault.
REQ-017 Both grill bits set, or both star bits set, holds that axis and raises fault.
REQ-018 Any grill bit together with any star bit in the same tick holds both axes and raises fault.
REQ-019 i_cmd = 0000 holds both counters; no fault.
REQ-020 Fault conditions are evaluated on tick cycles only; the command is sampled as present on that cycle.

Reset
REQ-021 While i_rst_n is low: grill counter = INIT_GRILL, star counter = INIT_STAR, prescaler = 0, o_fault = 0, applied asynchronously.
REQ-022 Reset mid-travel discards the partial position and reloads INIT values; first tick after release occurs STEP_DIV clocks after the first rising edge following release.

Configuration
REQ-023 With STAR_MODEL_FAULT_EN defined, o_fault sets on any fault condition and stays high until reset.
REQ-024 Without STAR_MODEL_FAULT_EN, o_fault is tied 0; interlock and hold behaviour in REQ-015..REQ-018 is unchanged.

Structure
REQ-025 Shared package star_pkg holds command bit indices (CMD_GRILL_OPEN=3, CMD_GRILL_CLOSE=2, CMD_STAR_RETRACT=1, CMD_STAR_EXTEND=0) and position codes (POS_LOW=2'b00, POS_HIGH=2'b01, POS_MID=2'b10), used by both this block and the star state machine.
REQ-026 One sub-module, star_axis, holds a saturating up/down counter plus position decode, parameterised by TRAVEL and INIT; it is instantiated twice.

Verification (GRILL_TRAVEL=4, STAR_TRAVEL=3, STEP_DIV=1, INIT 0/0, macro defined)
REQ-027 Reset, cmd 1000 for 4 clocks -> grill_pos 10,10,10,01; star_pos 00; fault 0.
REQ-028 Grill open, cmd 0010 for 3 clocks, then 0001 for 3 clocks -> star_pos 10,10,01, then 10,10,00; fault 0.
REQ-029 Grill open, star hidden, cmd 0100 -> grill holds at 01; fault 1 and stays 1 after cmd 0000.
REQ-030 Grill open, star up, cmd 0110 -> both axes hold; fault 1.
REQ-031 Grill at 2, cmd 1000 for 5 clocks -> grill reaches 01 and holds; fault 0; rst_n low mid-travel -> grill_pos 00 immediately.
REQ-032 STEP_DIV=4, cmd 1000 -> grill counter steps every 4th clock; grill_pos 01 after 16 clocks.

Source files
------------

// File: rtl/star_pkg.sv
// Shared definitions for the star actuator model and the star state machine:
// command bit indices, position codes and the counter-to-position decode.
package star_pkg;

  // Bit positions inside the 4-bit motor command word.
  localparam int CMD_GRILL_OPEN   = 3;
  localparam int CMD_GRILL_CLOSE  = 2;
  localparam int CMD_STAR_RETRACT = 1;
  localparam int CMD_STAR_EXTEND  = 0;

  // Position counters are wide enough for the largest legal travel (1023).
  localparam int CNT_W = 10;

  // Prescaler width covers the largest legal step divider (255).
  localparam int PRESC_W = 8;

  // Position codes; 2'b11 is never produced.
  typedef enum logic [1:0] {
    POS_LOW  = 2'b00,
    POS_HIGH = 2'b01,
    POS_MID  = 2'b10
  } pos_t;

  // Map a counter value onto its position code for an axis of given travel.
  function automatic pos_t decode_pos(input logic [CNT_W-1:0] cnt,
                                      input logic [CNT_W-1:0] travel);
    if (cnt == '0)          return POS_LOW;
    else if (cnt == travel) return POS_HIGH;
    else                    return POS_MID;
  endfunction

endpackage : star_pkg

// File: rtl/star_axis.sv
// One motion axis: saturating up/down step counter loaded with INIT at reset,
// plus a combinational decode of the counter into a position code.
// Callers qualify inc_i/dec_i with the step tick and interlocks.
module star_axis
  import star_pkg::*;
#(
  parameter int TRAVEL = 100,
  parameter int INIT   = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [1:0]       pos_o
);

  localparam logic [CNT_W-1:0] TRAVEL_C = CNT_W'(TRAVEL);
  localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(INIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: step toward the requested end, holding at either endpoint.
  always_comb begin
    // NOTE: cnt_d is given a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != TRAVEL_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Position register; reset reloads the initial position, dropping any
  // partial travel.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n_i) cnt_q <= INIT_C;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign pos_o = decode_pos(cnt_q, TRAVEL_C);

endmodule : star_axis

// File: rtl/star_actuator_model.sv
// Behavioural model of the grill + star actuator pair. A prescaler produces a
// step tick every STEP_DIV clocks; on each tick the command word moves the
// grill or the star one step, subject to the mechanical interlocks:
//   - the grill may only move while the star is fully extended (counter 0),
//   - the star may only move while the grill is fully open,
//   - contradictory or mixed grill/star commands hold both affected axes.
// Optional build macro STAR_MODEL_FAULT_EN: when defined, o_fault is a sticky
// flag set by any illegal command on a tick; otherwise o_fault is tied low and
// only the hold behaviour remains.
module star_actuator_model
  import star_pkg::*;
#(
  parameter int GRILL_TRAVEL = 100,
  parameter int STAR_TRAVEL  = 60,
  parameter int STEP_DIV     = 4,
  parameter int INIT_GRILL   = 0,
  parameter int INIT_STAR    = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_cmd,
  output logic [1:0] o_grill_pos,
  output logic [1:0] o_star_pos,
  output logic       o_fault
);

  localparam logic [PRESC_W-1:0] PRESC_MAX   = PRESC_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0]   GRILL_OPEN_C = CNT_W'(GRILL_TRAVEL);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick;

  logic [CNT_W-1:0]   grill_cnt, star_cnt;

  logic grill_open, grill_close, star_retract, star_extend;
  logic grill_any, star_any, grill_both, star_both, cross_cmd;
  logic ilk_a, ilk_b;
  logic grill_ok, star_ok;
  logic grill_inc, grill_dec, star_inc, star_dec;

  // Step prescaler: wraps 0..STEP_DIV-1, tick on the last count.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
  end

  // Prescaler register; restarts from 0 on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) presc_q <= '0;
    else          presc_q <= presc_d;
  end

  // Command decode and interlock qualification for both axes.
  always_comb begin
    grill_open   = i_cmd[CMD_GRILL_OPEN];
    grill_close  = i_cmd[CMD_GRILL_CLOSE];
    star_retract = i_cmd[CMD_STAR_RETRACT];
    star_extend  = i_cmd[CMD_STAR_EXTEND];

    grill_any  = grill_open | grill_close;
    star_any   = star_retract | star_extend;
    grill_both = grill_open & grill_close;
    star_both  = star_retract & star_extend;
    cross_cmd  = grill_any & star_any;

    // Grill must not move unless the star is fully extended, and vice versa
    // the star must not move unless the grill is fully open.
    ilk_a = grill_any & (star_cnt != '0);
    ilk_b = star_any & (grill_cnt != GRILL_OPEN_C);

    grill_ok = grill_any & ~grill_both & ~cross_cmd & ~ilk_a;
    star_ok  = star_any & ~star_both & ~cross_cmd & ~ilk_b;

    grill_inc = tick & grill_ok & grill_open;
    grill_dec = tick & grill_ok & grill_close;
    star_inc  = tick & star_ok & star_retract;
    star_dec  = tick & star_ok & star_extend;
  end

  star_axis #(
    .TRAVEL (GRILL_TRAVEL),
    .INIT   (INIT_GRILL)
  ) u_grill (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .inc_i   (grill_inc),
    .dec_i   (grill_dec),
    .cnt_o   (grill_cnt),
    .pos_o   (o_grill_pos)
  );

  star_axis #(
    .TRAVEL (STAR_TRAVEL),
    .INIT   (INIT_STAR)
  ) u_star (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .inc_i   (star_inc),
    .dec_i   (star_dec),
    .cnt_o   (star_cnt),
    .pos_o   (o_star_pos)
  );

`ifdef STAR_MODEL_FAULT_EN
  logic fault_q, fault_d;

  // Sticky fault: any illegal command seen on a tick sets it until reset.
  always_comb begin
    fault_d = fault_q |
              (tick & (grill_both | star_both | cross_cmd | ilk_a | ilk_b));
  end

  // Fault register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end

  assign o_fault = fault_q;
`else
  assign o_fault = 1'b0;
`endif

endmodule : star_actuator_model

// File: tb/tb_star_actuator_model.sv
// Self-checking bench for star_actuator_model. Main DUT: GRILL_TRAVEL=4,
// STAR_TRAVEL=3, STEP_DIV=1; a second instance with STEP_DIV=4 checks tick
// spacing. Expected codes come from a small behavioural model and are queued
// when a command is driven, then popped and compared after the clock edge.
module tb_star_actuator_model;

  localparam int GT = 4;
  localparam int ST = 3;

`ifdef STAR_MODEL_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [1:0] g;
    logic [1:0] s;
    logic       f;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cmd = 4'b0000;
  logic [3:0] cmd4 = 4'b0000;
  logic [1:0] gpos, spos, gpos4, spos4;
  logic       fault, fault4;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  int   m_grill = 0;
  int   m_star  = 0;
  bit   m_fault = 1'b0;

  always #5 clk = ~clk;

  star_actuator_model #(
    .GRILL_TRAVEL (GT), .STAR_TRAVEL (ST), .STEP_DIV (1),
    .INIT_GRILL (0), .INIT_STAR (0)
  ) dut (
    .i_clk (clk), .i_rst_n (rst_n), .i_cmd (cmd),
    .o_grill_pos (gpos), .o_star_pos (spos), .o_fault (fault)
  );

  star_actuator_model #(
    .GRILL_TRAVEL (GT), .STAR_TRAVEL (ST), .STEP_DIV (4),
    .INIT_GRILL (0), .INIT_STAR (0)
  ) dut4 (
    .i_clk (clk), .i_rst_n (rst_n), .i_cmd (cmd4),
    .o_grill_pos (gpos4), .o_star_pos (spos4), .o_fault (fault4)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] enc(input int c, input int t);
    if (c == 0)      return 2'b00;
    else if (c == t) return 2'b01;
    else             return 2'b10;
  endfunction

  // Reference behaviour for one step tick.
  task automatic model_step(input logic [3:0] c);
    bit g_req, s_req, bad;
    g_req = c[3] | c[2];
    s_req = c[1] | c[0];
    bad   = 1'b0;
    if (g_req && s_req) begin
      bad = 1'b1;
    end else if (g_req) begin
      if (c[3] && c[2])      bad = 1'b1;
      else if (m_star != 0)  bad = 1'b1;
      else if (c[3])         m_grill = (m_grill < GT) ? m_grill + 1 : m_grill;
      else                   m_grill = (m_grill > 0) ? m_grill - 1 : m_grill;
    end else if (s_req) begin
      if (c[1] && c[0])      bad = 1'b1;
      else if (m_grill != GT) bad = 1'b1;
      else if (c[1])         m_star = (m_star < ST) ? m_star + 1 : m_star;
      else                   m_star = (m_star > 0) ? m_star - 1 : m_star;
    end
    if (bad && FAULT_EN) m_fault = 1'b1;
  endtask

  // Drive one command for one clock; expectation queued, compared after edge.
  task automatic drive(input logic [3:0] c, input string tag);
    exp_t e, got;
    cmd = c;
    model_step(c);
    e.tag = tag;
    e.g   = enc(m_grill, GT);
    e.s   = enc(m_star, ST);
    e.f   = m_fault;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      got = sb.pop_front();
      check({got.tag, "_g"}, int'(gpos), int'(got.g));
      check({got.tag, "_s"}, int'(spos), int'(got.s));
      check({got.tag, "_f"}, int'(fault), int'(got.f));
    end
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    cmd   = 4'b0000;
    #1;
    check({tag, "_g"}, int'(gpos), 0);
    check({tag, "_s"}, int'(spos), 0);
    check({tag, "_f"}, int'(fault), 0);
    m_grill = 0;
    m_star  = 0;
    m_fault = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] pick [6];
    pick[0] = 4'b0000; pick[1] = 4'b1000; pick[2] = 4'b0100;
    pick[3] = 4'b0010; pick[4] = 4'b0001; pick[5] = 4'b0000;

    // Reset state of both instances.
    #1;
    check("rst0_g", int'(gpos), 0);
    check("rst0_s", int'(spos), 0);
    check("rst0_f", int'(fault), 0);
    check("rst0_g4", int'(gpos4), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmd4  = 4'b1000;

    // STEP_DIV=4: counter moves on edges 4, 8, 12, 16 after release.
    for (int k = 1; k <= 16; k++) begin
      drive(4'b0000, "idle");
      check($sformatf("div4_g_%0d", k), int'(gpos4),
            int'((k == 16) ? 2'b01 : ((k >= 4) ? 2'b10 : 2'b00)));
    end
    check("div4_s", int'(spos4), 0);
    check("div4_f", int'(fault4), 0);

    // Grill opens in four ticks.
    for (int k = 0; k < 4; k++) drive(4'b1000, "open");
    check("open_done", int'(gpos), 2'b01);
    // Star retracts to hidden, then extends back.
    for (int k = 0; k < 3; k++) drive(4'b0010, "retract");
    check("hidden", int'(spos), 2'b01);
    for (int k = 0; k < 3; k++) drive(4'b0001, "extend");
    check("extended", int'(spos), 2'b00);
    check("legal_nofault", int'(fault), 0);
    // Saturation at both endpoints is not a fault.
    drive(4'b0001, "star_sat0");
    drive(4'b1000, "grill_satT");
    // Mixed grill + star command holds both axes.
    drive(4'b0110, "cross");
    check("cross_fault", int'(fault), int'(FAULT_EN));
    drive(4'b0000, "cross_idle");

    // Interlock A: grill close while star hidden.
    do_reset("rst1");
    for (int k = 0; k < 4; k++) drive(4'b1000, "open2");
    for (int k = 0; k < 3; k++) drive(4'b0010, "hide2");
    drive(4'b0100, "ilk_a");
    check("ilk_a_hold", int'(gpos), 2'b01);
    drive(4'b0000, "ilk_a_idle");
    check("ilk_a_sticky", int'(fault), int'(FAULT_EN));

    // Interlock B and contradictory bits from closed state.
    do_reset("rst2");
    drive(4'b0100, "grill_sat0");
    drive(4'b0010, "ilk_b");
    do_reset("rst3");
    drive(4'b1100, "grill_both");
    do_reset("rst4");
    for (int k = 0; k < 4; k++) drive(4'b1000, "open3");
    drive(4'b0011, "star_both");

    // Grill from 2: reaches open and holds; then reset mid-travel.
    do_reset("rst5");
    for (int k = 0; k < 2; k++) drive(4'b1000, "to2");
    for (int k = 0; k < 5; k++) drive(4'b1000, "from2");
    check("from2_open", int'(gpos), 2'b01);
    do_reset("rst6");
    for (int k = 0; k < 2; k++) drive(4'b1000, "mid");
    do_reset("rst_mid");

    // Mostly-legal random command stream.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) drive(4'($urandom_range(0, 15)), "rnd");
      else drive(pick[$urandom_range(0, 5)], "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_star_actuator_model
